// File: rtl/multiport_rom.sv
// rtl/multiport_rom.sv - multi-port read-only memory with independent stall-able read pipelines
module multiport_rom #(
    parameter string CONTENTS = "",
    parameter int    DEPTH    = 1024,
    parameter int    LATENCY  = 2,
    parameter int    PORTS    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i [PORTS],
    input  logic [31:0] req_addr_i  [PORTS],
    output logic        req_ready_o [PORTS],
    output logic        rsp_valid_o [PORTS],
    output logic [31:0] rsp_data_o  [PORTS],
    output logic        rsp_err_o   [PORTS],
    input  logic        rsp_ready_i [PORTS]
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    // Image load at elaboration; an empty image leaves an all-zero ROM
    initial begin
        int          widx;
        logic [31:0] acc;
        bit          have;
        byte         ch;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
        widx = 0;
        acc  = '0;
        have = 1'b0;
        for (int c = 0; c < CONTENTS.len(); c++) begin
            ch = CONTENTS[c];
            if (ch >= "0" && ch <= "9") begin
                acc  = {acc[27:0], 4'(ch - "0")};
                have = 1'b1;
            end else if (ch >= "a" && ch <= "f") begin
                acc  = {acc[27:0], 4'(ch - "a" + 10)};
                have = 1'b1;
            end else if (ch >= "A" && ch <= "F") begin
                acc  = {acc[27:0], 4'(ch - "A" + 10)};
                have = 1'b1;
            end else if (have) begin
                if (widx < DEPTH) mem[widx] = acc;
                widx++;
                acc  = '0;
                have = 1'b0;
            end
        end
        if (have && widx < DEPTH) begin
            mem[widx] = acc;
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic          st_valid [LATENCY];
        logic          st_err   [LATENCY];
        logic [31:0]   st_data  [LATENCY];
        logic          adv;
        logic          req_err;
        logic [AW-1:0] idx;

        // The whole pipeline moves only when the output slot is free or being consumed
        assign adv = !st_valid[LATENCY-1] || rsp_ready_i[p];
        assign idx = req_addr_i[p][AW+1:2];
        // Upper bits are checked explicitly so out-of-range addresses never alias
        assign req_err = (req_addr_i[p][1:0] != 2'b00) ||
                         (req_addr_i[p][31:AW+2] != '0);

        // Stage 0 is the memory output register; later stages form a shift chain
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < LATENCY; i++) begin
                    st_valid[i] <= 1'b0;
                    st_err[i]   <= 1'b0;
                    st_data[i]  <= '0;
                end
            end else if (adv) begin
                st_valid[0] <= req_valid_i[p];
                st_err[0]   <= req_valid_i[p] && req_err;
                st_data[0]  <= (req_valid_i[p] && !req_err) ? mem[idx] : '0;
                for (int i = 1; i < LATENCY; i++) begin
                    st_valid[i] <= st_valid[i-1];
                    st_err[i]   <= st_err[i-1];
                    st_data[i]  <= st_data[i-1];
                end
            end
        end

        assign req_ready_o[p] = adv;
        assign rsp_valid_o[p] = st_valid[LATENCY-1];
        assign rsp_err_o[p]   = st_err[LATENCY-1];
        assign rsp_data_o[p]  = st_data[LATENCY-1];
    end

endmodule

// File: tb/tb_multiport_rom.sv
// tb/tb_multiport_rom.sv - scoreboard bench for multiport_rom
module tb_multiport_rom;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid [2];
    logic [31:0] req_addr  [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic        rsp_ready [2];
    int          rsp_cnt   [2];

    logic        sw_req_valid [1];
    logic [31:0] sw_req_addr  [1];
    logic        sw_rsp_ready [1];
    int          sw_acc [3];
    int          sw_vld [3];
    int          sw_cnt [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input int depth);
        logic err;
        err = (a[1:0] != 2'b00) || (a >= 32'(depth * 4));
        return err ? {1'b1, 32'h0} : {1'b0, 32'hA5000000 | (a >> 2)};
    endfunction

    function automatic int sw_lat(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    multiport_rom #(.DEPTH(1024), .LATENCY(2), .PORTS(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .rsp_ready_i(rsp_ready)
    );

    // Scoreboard per main port: push on accept, compare front while valid, pop on handshake
    for (genvar p = 0; p < 2; p++) begin : g_mon
        logic [32:0] q[$];
        logic [32:0] e;
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                if (req_valid[p] && req_ready[p]) q.push_back(model(req_addr[p], 1024));
                if (rsp_valid[p]) begin
                    if (q.size() == 0) begin
                        check($sformatf("p%0d_unexpected_rsp", p), 32'd1, 32'd0);
                    end else begin
                        e = q[0];
                        check($sformatf("p%0d_data", p), rsp_data[p], e[31:0]);
                        check($sformatf("p%0d_err", p), 32'(rsp_err[p]), 32'(e[32]));
                        if (rsp_ready[p]) begin
                            void'(q.pop_front());
                            rsp_cnt[p]++;
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int LAT = sw_lat(g);
        logic        rdy [1];
        logic        vld [1];
        logic        er  [1];
        logic [31:0] dat [1];
        logic [32:0] q[$];
        logic [32:0] e;

        multiport_rom #(.DEPTH(16), .LATENCY(LAT), .PORTS(1)) u_rom (
            .clk_i(clk), .rst_ni(rst_n),
            .req_valid_i(sw_req_valid), .req_addr_i(sw_req_addr), .req_ready_o(rdy),
            .rsp_valid_o(vld), .rsp_data_o(dat), .rsp_err_o(er),
            .rsp_ready_i(sw_rsp_ready)
        );

        initial begin
            #1;
            for (int k = 0; k < 16; k++) u_rom.mem[k] = 32'hA5000000 | 32'(k);
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                if (sw_req_valid[0] && rdy[0]) begin
                    q.push_back(model(sw_req_addr[0], 16));
                    if (sw_acc[g] < 0) sw_acc[g] = cyc;
                end
                if (vld[0]) begin
                    if (sw_vld[g] < 0) sw_vld[g] = cyc;
                    if (q.size() == 0) begin
                        check($sformatf("sw%0d_unexpected_rsp", g), 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sw%0d_data", g), dat[0], e[31:0]);
                        check($sformatf("sw%0d_err", g), 32'(er[0]), 32'(e[32]));
                        sw_cnt[g]++;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] addrs [4];
    logic [31:0] eaddr [3];
    int base;
    int ai;

    initial begin
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0;
            req_addr[p]  = '0;
            rsp_ready[p] = 1'b1;
            rsp_cnt[p]   = 0;
        end
        for (int g = 0; g < 3; g++) begin
            sw_acc[g] = -1;
            sw_vld[g] = -1;
            sw_cnt[g] = 0;
        end
        sw_req_valid[0] = 1'b0;
        sw_req_addr[0]  = '0;
        sw_rsp_ready[0] = 1'b1;
        #1;
        for (int k = 0; k < 1024; k++) dut.mem[k] = 32'hA5000000 | 32'(k);

        // Reset state
        #11;
        for (int p = 0; p < 2; p++) begin
            check("rst_valid", 32'(rsp_valid[p]), 32'd0);
            check("rst_data", rsp_data[p], 32'd0);
            check("rst_err", 32'(rsp_err[p]), 32'd0);
            check("rst_ready", 32'(req_ready[p]), 32'd1);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Streaming read
        base = rsp_cnt[0];
        for (int k = 0; k < 6; k++) begin
            req_valid[0] = (k < 4);
            req_addr[0]  = 32'(k * 4);
            @(negedge clk);
            if (k < 4) check("stream_ready", 32'(req_ready[0]), 32'd1);
            check($sformatf("stream_valid_c%0d", k), 32'(rsp_valid[0]), 32'(k >= 2));
            tick();
        end
        check("stream_count", 32'(rsp_cnt[0] - base), 32'd4);

        // Backpressure
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
        base = rsp_cnt[0];
        ai = 0;
        for (int k = 0; k < 12; k++) begin
            rsp_ready[0] = !(k >= 2 && k < 5);
            req_valid[0] = (ai < 4);
            req_addr[0]  = (ai < 4) ? addrs[ai] : 32'h0;
            @(negedge clk);
            if (k >= 2 && k < 5) begin
                check("bp_ready_low", 32'(req_ready[0]), 32'd0);
                check("bp_valid_held", 32'(rsp_valid[0]), 32'd1);
                check("bp_data_held", rsp_data[0], 32'hA5000000);
            end
            if (req_valid[0] && req_ready[0]) ai++;
            tick();
        end
        rsp_ready[0] = 1'b1;
        check("bp_count", 32'(rsp_cnt[0] - base), 32'd4);

        // Error requests, then a good one
        eaddr[0] = 32'h6; eaddr[1] = 32'h1000; eaddr[2] = 32'h8;
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = (k < 3);
            req_addr[0]  = (k < 3) ? eaddr[k] : 32'h0;
            @(negedge clk);
            if (k >= 2) begin
                check($sformatf("err_flag_c%0d", k), 32'(rsp_err[0]), 32'(k < 4));
                check($sformatf("err_data_c%0d", k), rsp_data[0], (k < 4) ? 32'h0 : 32'hA5000002);
            end
            tick();
        end

        // Port independence: port 1 stalled with its first response, port 0 streams 8
        rsp_ready[1] = 1'b0;
        base = rsp_cnt[0];
        for (int k = 0; k < 10; k++) begin
            req_valid[0] = (k < 8);
            req_addr[0]  = 32'(k * 4);
            req_valid[1] = (k == 0);
            req_addr[1]  = 32'h0;
            @(negedge clk);
            if (k < 8) check("ind_p0_ready", 32'(req_ready[0]), 32'd1);
            check($sformatf("ind_p0_valid_c%0d", k), 32'(rsp_valid[0]), 32'(k >= 2));
            if (k >= 2) begin
                check("ind_p1_held_valid", 32'(rsp_valid[1]), 32'd1);
                check("ind_p1_held_data", rsp_data[1], 32'hA5000000);
                check("ind_p1_ready_low", 32'(req_ready[1]), 32'd0);
            end
            tick();
        end
        check("ind_p0_count", 32'(rsp_cnt[0] - base), 32'd8);
        rsp_ready[1] = 1'b1;
        tick();
        tick();
        check("ind_p1_count", 32'(rsp_cnt[1]), 32'd1);

        // Mid-flight reset with two requests in flight
        for (int k = 0; k < 2; k++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = 32'(k * 4);
            tick();
        end
        req_valid[0] = 1'b0;
        check("pre_rst_valid", 32'(rsp_valid[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(rsp_valid[0]), 32'd0);
        check("mrst_ready", 32'(req_ready[0]), 32'd1);
        check("mrst_data", rsp_data[0], 32'd0);
        check("mrst_err", 32'(rsp_err[0]), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(rsp_valid[0]), 32'd0);
            tick();
        end

        // Latency sweep on DEPTH=16 instances
        eaddr[0] = 32'h0;
        for (int k = 0; k < 12; k++) begin
            sw_req_valid[0] = (k < 5);
            sw_req_addr[0]  = (k < 4) ? 32'(k * 4) : 32'h40;
            tick();
        end
        sw_req_valid[0] = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("sw%0d_latency", g), 32'(sw_vld[g] - sw_acc[g]), 32'(sw_lat(g)));
            check($sformatf("sw%0d_count", g), 32'(sw_cnt[g]), 32'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiport_rom.md
# multiport_rom

Parametrised read-only memory with `PORTS` independent read ports, configurable depth and read latency, a valid/ready handshake with backpressure, and an error flag for misaligned or out-of-range addresses. It is the next-generation boot/firmware ROM. It sits between the core's fetch/load paths (and any debug or DMA reader) and a preloaded word array. Each port is an independent stall-able pipeline; ports never interact.

## Interface
- `CONTENTS`, default `""`: hex image loaded at elaboration; an empty string means all words are 0.
- `DEPTH`, default `1024`: words of storage; power of two, 16..65536.
- `LATENCY`, default `2`: read latency in accepted-cycle stages, 1..4.
- `PORTS`, default `2`: number of independent read ports, 1..4.
- `clk_i`  in  1  single clock; all state on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i[PORTS]`  in  1 each  request present.
- `req_addr_i[PORTS]`  in  `word_t` each  byte address.
- `req_ready_o[PORTS]`  out  1 each  port can accept a request this cycle.
- `rsp_valid_o[PORTS]`  out  1 each  response present.
- `rsp_data_o[PORTS]`  out  `word_t` each  read word; 0 when error.
- `rsp_err_o[PORTS]`  out  1 each  request was misaligned or out of range.
- `rsp_ready_i[PORTS]`  in  1 each  consumer accepts the response.

## Operation
- Word index = `addr[AW+1:2]`, where `AW = $clog2(DEPTH)`.
- Error conditions:
  - `addr[1:0] != 0` is an error.
  - `addr >= DEPTH*4` is an error; upper bits are compared, with no aliasing.
  - An error request does not read memory. It returns data 0 with `rsp_err_o = 1`.
- Each port has a `LATENCY`-stage pipeline. Each stage holds `{valid, err, data}`. Stage 0 captures the memory read.
- Advance condition per port: `adv = !rsp_valid_o || rsp_ready_i`.
  - When `adv = 1`, every stage shifts forward by one.
  - Stage 0 loads `{req_valid_i, err, mem[idx]}`.
  - A cycle with no request inserts a bubble (`valid = 0`).
- When `adv = 0`, every stage, including the memory output register, holds its value. This is the BRAM clock-enable semantic.
- `req_ready_o = adv`, combinational from `rsp_valid_o` and `rsp_ready_i`. A request transfers on `req_valid_i && req_ready_o`.
- Responses return in request order per port. Bubbles are not compacted.
- Ports are fully independent. Stall, error or reset activity on one port never affects another. Identical addresses on all ports in the same cycle are legal.
- Memory is never written after elaboration.

## Timing
- Reset (`rst_ni` low, asynchronous):
  - All stage valid, err and data clear to 0 immediately.
  - `rsp_valid_o = 0`, `rsp_data_o = 0`, `rsp_err_o = 0`.
  - `req_ready_o = 1`, because `rsp_valid_o = 0`.
- Reset mid-operation discards all in-flight requests; none are replayed.
- The first request may be accepted on the first rising edge after `rst_ni` deasserts. Deassertion is synchronised externally.
- Latency: a request accepted at edge N with no stalls produces `rsp_valid_o = 1` and the data after edge N+`LATENCY`−1. It is visible during cycle N+`LATENCY`−1…N+`LATENCY`, and with `LATENCY = 1` it is visible in the cycle after acceptance.
- Each stall cycle (`rsp_valid_o && !rsp_ready_i`) delays every in-flight entry by exactly one cycle.
- `rsp_data_o` and `rsp_err_o` are stable while `rsp_valid_o && !rsp_ready_i`.
- Throughput is one request per cycle per port with `rsp_ready_i` held high.
- Outputs are registered. `req_ready_o` is the only combinational output.

## Test plan
- Streaming read:
  - Stimulus: `LATENCY = 2`; image word k = `0xA5000000 | k`; port 0 requests addresses 0, 4, 8, 12 on consecutive cycles with `rsp_ready_i = 1`.
  - Required response: `rsp_valid_o` high for 4 consecutive cycles starting 2 edges after the first accept, data `0xA5000000`..`0xA5000003`, err 0.
- Backpressure:
  - Stimulus: same stream; drop `rsp_ready_i` for 3 cycles after the first response.
  - Required response: `req_ready_o = 0` for those 3 cycles; data held at `0xA5000000`; no loss or duplication; total of 4 responses in order.
- Errors:
  - Stimulus: request `0x00000006` (misaligned) and `DEPTH*4` (`0x1000`).
  - Required response: each returns `rsp_err_o = 1`, data 0, at normal latency. The next request to address 8 returns `0xA5000002`, err 0.
- Port independence:
  - Stimulus: `PORTS = 2`; port 1 is stalled indefinitely while port 0 streams 8 reads; both ports read address 0 in the same cycle.
  - Required response: port 0 completes all 8 reads at full rate; port 1 holds its first response unchanged.
- Mid-flight reset:
  - Stimulus: assert `rst_ni = 0` asynchronously between edges with 2 requests in flight.
  - Required response: `rsp_valid_o` falls to 0 immediately, `req_ready_o = 1`, and no stale response appears after release.
- Latency sweep:
  - Stimulus: repeat the streaming-read scenario for `LATENCY` = 1, 3, 4 and `DEPTH = 16`.
  - Required response: first `rsp_valid_o` appears exactly `LATENCY` edges after acceptance; address `0x40` flags err.
